// File: rtl/pcs_frame_pkg.sv
// Shared definitions for the frame checker delay-search sequencer.
package pcs_frame_pkg;

  localparam int DEF_MAX_DELAY = 2048;
  localparam int DEF_N_BLOCKS  = 2048;

  // Sequencer states. SETTLE is shared by the sweep and the locked path.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_SWEEP   = 3'd2,
    ST_EVAL    = 3'd3,
    ST_MONITOR = 3'd4,
    ST_FAIL    = 3'd5
  } align_state_e;

  // A valid compare block is an error unless both the ctrl and data lanes matched.
  function automatic logic block_error(input logic valid, input logic ctrl, input logic data);
    return valid && !(ctrl && data);
  endfunction

endpackage

// File: rtl/align_window_cnt.sv
// Valid-block window counter with saturating error accumulator.
// In settle mode it counts SETTLE valid blocks and ignores errors;
// otherwise it counts N_BLOCKS valid blocks and accumulates errors.
// o_done pulses on the last valid block of the window; o_err_total
// already includes that block's error so the caller can latch it directly.
module align_window_cnt
  import pcs_frame_pkg::*;
#(
  parameter int N_BLOCKS = DEF_N_BLOCKS,
  parameter int SETTLE   = 2,
  parameter int NB_CNT   = $clog2(N_BLOCKS + 1)
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_enable,
  input  logic              i_clear,
  input  logic              i_settle_mode,
  input  logic              i_valid,
  input  logic              i_error,
  output logic              o_done,
  output logic [NB_CNT-1:0] o_err_total
);

  localparam logic [NB_CNT-1:0] WIN_LAST = NB_CNT'(N_BLOCKS - 1);
  localparam logic [NB_CNT-1:0] SET_LAST = NB_CNT'(SETTLE - 1);
  localparam logic [NB_CNT-1:0] ERR_SAT  = NB_CNT'(N_BLOCKS);

  logic [NB_CNT-1:0] blk_cnt;
  logic [NB_CNT-1:0] err_cnt;
  logic [NB_CNT-1:0] last_blk;
  logic              err_inc;

  // Window end detection and running error total including this block.
  always_comb begin
    last_blk    = i_settle_mode ? SET_LAST : WIN_LAST;
    o_done      = i_valid && (blk_cnt == last_blk);
    err_inc     = i_valid && i_error && !i_settle_mode && (err_cnt < ERR_SAT);
    o_err_total = err_cnt + {{(NB_CNT-1){1'b0}}, err_inc};
  end

  // Counters advance on valid blocks only; window end wraps both to zero.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      blk_cnt <= '0;
      err_cnt <= '0;
    end else if (i_enable) begin
      if (i_clear || o_done) begin
        blk_cnt <= '0;
        err_cnt <= '0;
      end else if (i_valid) begin
        blk_cnt <= blk_cnt + NB_CNT'(1);
        err_cnt <= o_err_total;
      end
    end
  end

endmodule

// File: rtl/frame_align_ctrl.sv
// Delay-search sequencer: sweeps the shift-memory read pointer over all
// candidate delays, locks on the delay with the fewest window errors and
// monitors the locked link, re-sweeping after sustained loss.
//
// Handshake: i_match_valid qualifies i_match_ctrl/i_match_data for one cycle;
// there is no backpressure, every valid block on an enabled cycle is consumed.
module frame_align_ctrl
  import pcs_frame_pkg::*;
#(
  parameter  int MAX_DELAY    = DEF_MAX_DELAY,
  parameter  int N_BLOCKS     = DEF_N_BLOCKS,
  parameter  int SETTLE       = 2,
  parameter  int LOSS_THR     = 16,
  parameter  int LOSS_WINDOWS = 3,
  localparam int NB_ADDR      = $clog2(MAX_DELAY),
  localparam int NB_CNT       = $clog2(N_BLOCKS + 1)
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_enable,
  input  logic               i_start,
  input  logic               i_match_valid,
  input  logic               i_match_ctrl,
  input  logic               i_match_data,
  output logic [NB_ADDR-1:0] o_read_ptr,
  output logic               o_searching,
  output logic               o_lock,
  output logic               o_fail,
  output logic [NB_ADDR-1:0] o_best_delay,
  output logic [NB_CNT-1:0]  o_min_error,
  output logic [NB_CNT-1:0]  o_window_errors,
  output align_state_e       o_dbg_state
);

  localparam int                 NB_BAD     = $clog2(LOSS_WINDOWS + 1);
  localparam logic [NB_CNT-1:0]  THR        = NB_CNT'(LOSS_THR);
  localparam logic [NB_BAD-1:0]  BAD_LAST   = NB_BAD'(LOSS_WINDOWS - 1);
  localparam logic [NB_ADDR-1:0] DELAY_LAST = NB_ADDR'(MAX_DELAY - 1);

  align_state_e       state, state_n;
  logic [NB_ADDR-1:0] ptr_n, best_n;
  logic [NB_CNT-1:0]  min_n, werr_n;
  logic               fail_n;
  logic [NB_BAD-1:0]  bad_cnt, bad_n;
  logic               locked_path, locked_path_n;
  logic               cnt_clear;
  logic               blk_error;
  logic               win_done;
  logic [NB_CNT-1:0]  err_total;

  assign blk_error   = block_error(i_match_valid, i_match_ctrl, i_match_data);
  assign o_dbg_state = state;

  align_window_cnt #(
    .N_BLOCKS (N_BLOCKS),
    .SETTLE   (SETTLE),
    .NB_CNT   (NB_CNT)
  ) u_win (
    .i_clock       (i_clock),
    .i_reset_n     (i_reset_n),
    .i_enable      (i_enable),
    .i_clear       (cnt_clear),
    .i_settle_mode (state == ST_SETTLE),
    .i_valid       (i_match_valid),
    .i_error       (blk_error),
    .o_done        (win_done),
    .o_err_total   (err_total)
  );

  // Next-state and next-output decisions; i_start overrides everything.
  always_comb begin
    state_n       = state;
    ptr_n         = o_read_ptr;
    best_n        = o_best_delay;
    min_n         = o_min_error;
    werr_n        = o_window_errors;
    fail_n        = o_fail;
    bad_n         = bad_cnt;
    locked_path_n = locked_path;
    cnt_clear     = 1'b0;
    if (i_start) begin
      state_n       = ST_SETTLE;
      ptr_n         = '0;
      best_n        = '0;
      min_n         = '1;
      fail_n        = 1'b0;
      bad_n         = '0;
      locked_path_n = 1'b0;
      cnt_clear     = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          ptr_n     = '0;
          cnt_clear = 1'b1;
        end
        ST_SETTLE: begin
          if (win_done) state_n = locked_path ? ST_MONITOR : ST_SWEEP;
        end
        ST_SWEEP: begin
          if (win_done) begin
            werr_n = err_total;
            // Strict compare keeps the lowest delay on ties.
            if (err_total < o_min_error) begin
              min_n  = err_total;
              best_n = o_read_ptr;
            end
            if (o_read_ptr == DELAY_LAST) begin
              state_n = ST_EVAL;
            end else begin
              ptr_n   = o_read_ptr + NB_ADDR'(1);
              state_n = ST_SETTLE;
            end
          end
        end
        ST_EVAL: begin
          cnt_clear = 1'b1;
          if (o_min_error <= THR) begin
            ptr_n         = o_best_delay;
            bad_n         = '0;
            locked_path_n = 1'b1;
            state_n       = ST_SETTLE;
          end else begin
            fail_n  = 1'b1;
            state_n = ST_FAIL;
          end
        end
        ST_MONITOR: begin
          if (win_done) begin
            werr_n = err_total;
            if (err_total > THR) begin
              if (bad_cnt == BAD_LAST) begin
                // Sustained loss: restart the sweep from delay 0.
                state_n       = ST_SETTLE;
                ptr_n         = '0;
                best_n        = '0;
                min_n         = '1;
                bad_n         = '0;
                locked_path_n = 1'b0;
              end else begin
                bad_n = bad_cnt + NB_BAD'(1);
              end
            end else begin
              bad_n = '0;
            end
          end
        end
        ST_FAIL: begin
          cnt_clear = 1'b1;
        end
        default: begin
          state_n   = ST_IDLE;
          cnt_clear = 1'b1;
        end
      endcase
    end
  end

  // State and registered outputs; i_enable low freezes everything.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state           <= ST_IDLE;
      o_read_ptr      <= '0;
      o_best_delay    <= '0;
      o_min_error     <= '1;
      o_window_errors <= '0;
      o_fail          <= 1'b0;
      o_lock          <= 1'b0;
      o_searching     <= 1'b0;
      bad_cnt         <= '0;
      locked_path     <= 1'b0;
    end else if (i_enable) begin
      state           <= state_n;
      o_read_ptr      <= ptr_n;
      o_best_delay    <= best_n;
      o_min_error     <= min_n;
      o_window_errors <= werr_n;
      o_fail          <= fail_n;
      o_lock          <= (state_n == ST_MONITOR);
      o_searching     <= (state_n == ST_SETTLE) || (state_n == ST_SWEEP);
      bad_cnt         <= bad_n;
      locked_path     <= locked_path_n;
    end
  end

endmodule

// File: tb/tb_frame_align_ctrl.sv
// Bench for frame_align_ctrl: a model-driven generator plays the link
// (per-delay error budgets), pushes the expected outputs into a queue
// stamped with the cycle they become visible, and a negedge monitor
// pops and compares them.
module tb_frame_align_ctrl;
  import pcs_frame_pkg::*;

  localparam int MAXD = 8;
  localparam int NB   = 16;
  localparam int STL  = 2;
  localparam int THR  = 2;
  localparam int LW   = 3;
  localparam int MIN_RST = 31;

  localparam int ID_WERR = 0, ID_PTR = 1, ID_BEST = 2, ID_MIN = 3;
  localparam int ID_LOCK = 4, ID_FAIL = 5, ID_SRCH = 6, ID_STATE = 7;

  // ---------------- clock / reset / DUT ----------------
  logic         i_clock = 1'b0;
  logic         i_reset_n;
  logic         i_enable, i_start, i_match_valid, i_match_ctrl, i_match_data;
  logic [2:0]   o_read_ptr, o_best_delay;
  logic         o_searching, o_lock, o_fail;
  logic [4:0]   o_min_error, o_window_errors;
  align_state_e dbg_state;

  always #5 i_clock = ~i_clock;

  int cyc = 0;
  always @(posedge i_clock) cyc <= cyc + 1;

  frame_align_ctrl #(
    .MAX_DELAY(MAXD), .N_BLOCKS(NB), .SETTLE(STL), .LOSS_THR(THR), .LOSS_WINDOWS(LW)
  ) dut (
    .i_clock(i_clock), .i_reset_n(i_reset_n), .i_enable(i_enable), .i_start(i_start),
    .i_match_valid(i_match_valid), .i_match_ctrl(i_match_ctrl), .i_match_data(i_match_data),
    .o_read_ptr(o_read_ptr), .o_searching(o_searching), .o_lock(o_lock), .o_fail(o_fail),
    .o_best_delay(o_best_delay), .o_min_error(o_min_error),
    .o_window_errors(o_window_errors), .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    int          id;
    logic [31:0] exp;
    int          due;
  } chk_t;

  chk_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic string sig_name(input int id);
    case (id)
      ID_WERR: return "window_errors";
      ID_PTR:  return "read_ptr";
      ID_BEST: return "best_delay";
      ID_MIN:  return "min_error";
      ID_LOCK: return "lock";
      ID_FAIL: return "fail";
      ID_SRCH: return "searching";
      default: return "state";
    endcase
  endfunction

  function automatic logic [31:0] sig_value(input int id);
    case (id)
      ID_WERR: return 32'(o_window_errors);
      ID_PTR:  return 32'(o_read_ptr);
      ID_BEST: return 32'(o_best_delay);
      ID_MIN:  return 32'(o_min_error);
      ID_LOCK: return 32'(o_lock);
      ID_FAIL: return 32'(o_fail);
      ID_SRCH: return 32'(o_searching);
      default: return 32'(dbg_state);
    endcase
  endfunction

  task automatic expect_now(input int id, input int v);
    chk_t c;
    c.id  = id;
    c.exp = 32'(v);
    c.due = cyc;
    exp_q.push_back(c);
  endtask

  // Monitor: compare every expectation that has become visible.
  always @(negedge i_clock) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      chk_t        c;
      logic [31:0] act;
      c   = exp_q.pop_front();
      act = sig_value(c.id);
      checks++;
      if (act !== c.exp) begin
        errors++;
        $display("FAIL %s cycle %0d: got %0d expected %0d", sig_name(c.id), cyc, act, c.exp);
      end
    end
  end

  // ---------------- reference model ----------------
  int err_tab[MAXD];
  int m_best, m_min, m_bad;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic set_flags(input bit err);
    int k;
    if (err) begin
      k = $urandom_range(0, 2);
      {i_match_ctrl, i_match_data} = (k == 0) ? 2'b00 : ((k == 1) ? 2'b01 : 2'b10);
    end else begin
      {i_match_ctrl, i_match_data} = 2'b11;
    end
  endtask

  task automatic drive(input bit en, input bit v, input bit err, input bit st);
    i_enable      = en;
    i_match_valid = v;
    i_start       = st;
    set_flags(err);
    tick();
  endtask

  // Idle cycles between blocks: either not valid, or valid but frozen by enable.
  task automatic gap();
    int n;
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) drive(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
      else                           drive(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  task automatic valid_block(input bit err);
    gap();
    drive(1'b1, 1'b1, err, 1'b0);
  endtask

  task automatic settle();
    for (int i = 0; i < STL; i++) valid_block(1'($urandom_range(0, 1)));
  endtask

  // One window of NB valid blocks with exactly nerr errors at random positions.
  task automatic window(input int nerr);
    int rem;
    bit e;
    rem = nerr;
    for (int i = 0; i < NB; i++) begin
      e = (rem > 0) && ($urandom_range(0, NB - 1 - i) < rem);
      if (e) rem--;
      valid_block(e);
    end
  endtask

  task automatic do_start();
    drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    m_best = 0; m_min = MIN_RST; m_bad = 0;
    expect_now(ID_PTR, 0);  expect_now(ID_SRCH, 1); expect_now(ID_LOCK, 0);
    expect_now(ID_FAIL, 0); expect_now(ID_MIN, MIN_RST); expect_now(ID_BEST, 0);
  endtask

  task automatic sweep_window(input int d);
    settle();
    window(err_tab[d]);
    if (err_tab[d] < m_min) begin
      m_min  = err_tab[d];
      m_best = d;
    end
    expect_now(ID_WERR, err_tab[d]);
    expect_now(ID_MIN, m_min);
    expect_now(ID_BEST, m_best);
    expect_now(ID_PTR, (d < MAXD - 1) ? d + 1 : d);
    expect_now(ID_SRCH, (d < MAXD - 1) ? 1 : 0);
  endtask

  task automatic sweep_all(output bit locked);
    for (int d = 0; d < MAXD; d++) sweep_window(d);
    drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    if (m_min <= THR) begin
      expect_now(ID_PTR, m_best); expect_now(ID_SRCH, 1);
      expect_now(ID_LOCK, 0);     expect_now(ID_FAIL, 0);
      settle();
      expect_now(ID_LOCK, 1); expect_now(ID_SRCH, 0); expect_now(ID_PTR, m_best);
      m_bad  = 0;
      locked = 1'b1;
    end else begin
      expect_now(ID_FAIL, 1); expect_now(ID_LOCK, 0);
      expect_now(ID_SRCH, 0); expect_now(ID_PTR, MAXD - 1);
      locked = 1'b0;
    end
  endtask

  task automatic monitor_window(input int nerr, output bit lost);
    window(nerr);
    expect_now(ID_WERR, nerr);
    if (nerr > THR) m_bad++;
    else            m_bad = 0;
    if (m_bad == LW) begin
      lost = 1'b1;
      m_bad = 0; m_min = MIN_RST; m_best = 0;
      expect_now(ID_LOCK, 0); expect_now(ID_PTR, 0); expect_now(ID_SRCH, 1);
    end else begin
      lost = 1'b0;
      expect_now(ID_LOCK, 1); expect_now(ID_PTR, m_best); expect_now(ID_SRCH, 0);
    end
  endtask

  task automatic expect_reset_values();
    expect_now(ID_PTR, 0);  expect_now(ID_LOCK, 0); expect_now(ID_SRCH, 0);
    expect_now(ID_FAIL, 0); expect_now(ID_MIN, MIN_RST); expect_now(ID_BEST, 0);
    expect_now(ID_WERR, 0); expect_now(ID_STATE, int'(ST_IDLE));
  endtask

  task automatic idle_traffic();
    repeat (4) valid_block(1'($urandom_range(0, 1)));
    expect_now(ID_SRCH, 0); expect_now(ID_PTR, 0); expect_now(ID_LOCK, 0);
    expect_now(ID_STATE, int'(ST_IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit locked, lost;
    int mon_seq[6];
    i_reset_n = 1'b0; i_enable = 1'b0; i_start = 1'b0;
    i_match_valid = 1'b0; i_match_ctrl = 1'b0; i_match_data = 1'b0;
    repeat (2) @(posedge i_clock);
    #1;
    expect_reset_values();
    @(negedge i_clock);
    #1 i_reset_n = 1'b1;
    tick();
    idle_traffic();

    // Only delay 5 is clean.
    for (int d = 0; d < MAXD; d++) err_tab[d] = (d == 5) ? 0 : NB;
    do_start();
    sweep_all(locked);
    for (int i = 0; i < 2; i++) monitor_window($urandom_range(0, THR), lost);

    // Loss detection, including a good window that clears the bad count;
    // the link then changes so delays 3 and 6 tie at one error.
    for (int d = 0; d < MAXD; d++) err_tab[d] = (d == 3 || d == 6) ? 1 : $urandom_range(3, NB);
    mon_seq = '{4, 4, 1, 4, 4, 4};
    for (int i = 0; i < 6; i++) monitor_window(mon_seq[i], lost);
    sweep_all(locked);

    // Restart mid-sweep, then a sweep where every delay is bad.
    for (int d = 0; d < MAXD; d++) err_tab[d] = $urandom_range(3, NB);
    do_start();
    for (int d = 0; d < 3; d++) sweep_window(d);
    settle();
    repeat (5) valid_block(1'($urandom_range(0, 1)));
    do_start();
    sweep_all(locked);
    repeat (6) valid_block(1'($urandom_range(0, 1)));
    expect_now(ID_FAIL, 1); expect_now(ID_LOCK, 0); expect_now(ID_STATE, int'(ST_FAIL));

    // Start from FAIL with a random link that has one usable delay.
    for (int d = 0; d < MAXD; d++) err_tab[d] = $urandom_range(0, NB);
    err_tab[$urandom_range(0, MAXD - 1)] = $urandom_range(0, THR);
    do_start();
    sweep_all(locked);
    monitor_window($urandom_range(0, THR), lost);

    // Async reset in the middle of a monitor window.
    repeat (5) valid_block(1'($urandom_range(0, 1)));
    i_start = 1'b0; i_match_valid = 1'b0; i_enable = 1'b1;
    #1 i_reset_n = 1'b0;
    expect_reset_values();
    @(negedge i_clock);
    #1 i_reset_n = 1'b1;
    tick();
    idle_traffic();
    for (int d = 0; d < MAXD; d++) err_tab[d] = (d == 2) ? 1 : $urandom_range(2, NB);
    do_start();
    sweep_all(locked);

    repeat (3) tick();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
